// File: rtl/conv_layer_stream.sv
// conv_layer_stream: sequential FP16 convolution, one multiply-accumulate per cycle over a K x D x F x F bank.
// Latency: first result D*F*F+1 cycles after an accepted start, then one result every D*F*F+1 cycles.
// Backpressure: each result (data/k/row/col) is held with out_valid high until out_ready; MAC resumes after the handshake.
// Build option: define CONV_STREAM_RELU_EN to clamp negative results to 16'h0000 in the output register.
module conv_layer_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int D = 1,
  parameter int H = 4,
  parameter int W = 4,
  parameter int F = 2,
  parameter int K = 1,
  parameter int S = 1,
  localparam int OH  = (H - F) / S + 1,
  localparam int OW  = (W - F) / S + 1,
  localparam int KW  = $clog2(K) + 1,
  localparam int RW  = $clog2(OH) + 1,
  localparam int CW  = $clog2(OW) + 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           busy,
  input  logic [D*H*W*DATA_WIDTH-1:0]    image,
  input  logic [K*D*F*F*DATA_WIDTH-1:0]  filters,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [KW-1:0]                  out_k,
  output logic [RW-1:0]                  out_row,
  output logic [CW-1:0]                  out_col,
  output logic                           done
);

  localparam int DCW    = $clog2(D) + 1;
  localparam int FCW    = $clog2(F) + 1;
  localparam int IMG_BW = $clog2(D*H*W*DATA_WIDTH);
  localparam int FLT_BW = $clog2(K*D*F*F*DATA_WIDTH);

  localparam logic [DCW-1:0] D_LAST = DCW'(D - 1);
  localparam logic [FCW-1:0] F_LAST = FCW'(F - 1);
  localparam logic [KW-1:0]  K_LAST = KW'(K - 1);
  localparam logic [RW-1:0]  R_LAST = RW'(OH - 1);
  localparam logic [CW-1:0]  C_LAST = CW'(OW - 1);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DCW-1:0]        d_q, d_d;
  logic [FCW-1:0]        i_q, i_d, j_q, j_d;
  logic [KW-1:0]         k_q, k_d;
  logic [RW-1:0]         row_q, row_d;
  logic [CW-1:0]         col_q, col_d;

  int                    img_idx, flt_idx;
  logic [IMG_BW-1:0]     img_bit;
  logic [FLT_BW-1:0]     flt_bit;
  logic [DATA_WIDTH-1:0] img_e, flt_e, mac_sum;
  logic                  last_term, last_out;

  // FP16 multiply, round-to-nearest-even; zero/denormal inputs flush to signed zero, overflow saturates to inf.
  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [21:0] p;
    logic [11:0] m;
    logic        g, st;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = {1'b0, p[21:11]}; g = p[10]; st = |p[9:0]; e = e + 1;
    end else begin
      m = {1'b0, p[20:10]}; g = p[9];  st = |p[8:0];
    end
    if (g && (st || m[0])) m = m + 12'd1;
    if (m[11]) begin m = m >> 1; e = e + 1; end
    if (e >= 31) return {s, 5'h1f, 10'd0};
    if (e <= 0)  return {s, 15'd0};
    return {s, e[4:0], m[9:0]};
  endfunction

  // FP16 add with guard/round/sticky alignment; -0 + -0 stays -0, exact cancellation gives +0.
  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y;
    logic [13:0] mx, my;
    logic [14:0] sum;
    logic [11:0] m;
    logic        st;
    int          e, sh;
    if (a[14:10] == 5'd0 && b[14:10] == 5'd0) return {a[15] & b[15], 15'd0};
    if (b[14:10] == 5'd0) return a;
    if (a[14:10] == 5'd0) return b;
    if (a[14:0] >= b[14:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    mx = {1'b1, x[9:0], 3'b000};
    my = {1'b1, y[9:0], 3'b000};
    sh = int'(x[14:10]) - int'(y[14:10]);
    st = 1'b0;
    if (sh >= 14) my = 14'd1;
    else if (sh > 0) begin
      st = |(my & ((14'd1 << sh) - 14'd1));
      my = (my >> sh) | {13'd0, st};
    end
    e = int'(x[14:10]);
    if (x[15] == y[15]) sum = {1'b0, mx} + {1'b0, my};
    else                sum = {1'b0, mx} - {1'b0, my};
    if (sum == 15'd0) return 16'h0000;
    if (sum[14]) begin sum = (sum >> 1) | {14'd0, sum[0]}; e = e + 1; end
    for (int n = 0; n < 13; n++) begin
      if (!sum[13]) begin sum = sum << 1; e = e - 1; end
    end
    m = {1'b0, sum[13:3]};
    if (sum[2] && ((|sum[1:0]) || m[0])) m = m + 12'd1;
    if (m[11]) begin m = m >> 1; e = e + 1; end
    if (e >= 31) return {x[15], 5'h1f, 10'd0};
    if (e <= 0)  return {x[15], 15'd0};
    return {x[15], e[4:0], m[9:0]};
  endfunction

  // Optional clamp applied only when the finished sum is captured for output.
  function automatic logic [15:0] relu(input logic [15:0] v);
`ifdef CONV_STREAM_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  // Operand fetch for the current term: image (d, row*S+i, col*S+j) and filter (k, d, i, j).
  always_comb begin
    img_idx   = (int'(d_q) * H + int'(row_q) * S + int'(i_q)) * W + int'(col_q) * S + int'(j_q);
    flt_idx   = ((int'(k_q) * D + int'(d_q)) * F + int'(i_q)) * F + int'(j_q);
    img_bit   = IMG_BW'(img_idx * DATA_WIDTH);
    flt_bit   = FLT_BW'(flt_idx * DATA_WIDTH);
    img_e     = image[img_bit +: DATA_WIDTH];
    flt_e     = filters[flt_bit +: DATA_WIDTH];
    mac_sum   = fadd(acc_q, fmul(img_e, flt_e));
    last_term = (d_q == D_LAST) && (i_q == F_LAST) && (j_q == F_LAST);
    last_out  = (k_q == K_LAST) && (row_q == R_LAST) && (col_q == C_LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: start only counts in IDLE, so a pulse while busy or in DONE is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_MAC;
      S_MAC:   if (last_term) state_d = S_OUT;
      S_OUT:   if (out_ready) state_d = last_out ? S_DONE : S_MAC;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: status decoded from state, result fields straight from their holding registers.
  always_comb begin
    busy      = (state_q == S_MAC) || (state_q == S_OUT);
    out_valid = (state_q == S_OUT);
    done      = (state_q == S_DONE);
    out_data  = out_data_q;
    out_k     = k_q;
    out_row   = row_q;
    out_col   = col_q;
  end

  // Datapath next-state: term counters scan d, i, j (j fastest); output counters scan k, row, col (col fastest).
  always_comb begin
    acc_d      = acc_q;
    out_data_d = out_data_q;
    d_d        = d_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    row_d      = row_q;
    col_d      = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0; d_d = '0; i_d = '0; j_d = '0;
          k_d   = '0; row_d = '0; col_d = '0;
        end
      end
      S_MAC: begin
        acc_d = mac_sum;
        if (j_q != F_LAST) j_d = j_q + 1'b1;
        else begin
          j_d = '0;
          if (i_q != F_LAST) i_d = i_q + 1'b1;
          else begin
            i_d = '0;
            d_d = (d_q == D_LAST) ? '0 : d_q + 1'b1;
          end
        end
        if (last_term) out_data_d = relu(mac_sum);
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d = '0;
          if (!last_out) begin
            if (col_q != C_LAST) col_d = col_q + 1'b1;
            else begin
              col_d = '0;
              if (row_q != R_LAST) row_d = row_q + 1'b1;
              else begin
                row_d = '0;
                k_d   = k_q + 1'b1;
              end
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial sum.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      out_data_q <= '0;
      d_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      k_q        <= '0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
      d_q        <= d_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      row_q      <= row_d;
      col_q      <= col_d;
    end
  end

endmodule

// File: tb/tb_conv_layer_stream.sv
module tb_conv_layer_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, out_ready;
  int   sel;
  int   checks = 0;
  int   errors = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  k;
    logic [7:0]  row;
    logic [7:0]  col;
  } exp_t;
  exp_t sb[$];

  // A: D=1 H=W=4 F=2 K=1 S=1
  logic         start_a, busy_a, vld_a, done_a;
  logic [15:0]  data_a;
  logic [0:0]   k_a;
  logic [2:0]   row_a, col_a;
  logic [255:0] img_a  = {16{16'h3C00}};
  logic [63:0]  flt_a  = {4{16'h3C00}};
  // B: D=1 H=W=5 F=3 K=1 S=2
  logic         start_b, busy_b, vld_b, done_b;
  logic [15:0]  data_b;
  logic [0:0]   k_b;
  logic [1:0]   row_b, col_b;
  logic [399:0] img_b  = {25{16'h3C00}};
  logic [143:0] flt_b  = {9{16'h3800}};
  // C: D=2 H=W=3 F=2 K=2 S=1
  logic         start_c, busy_c, vld_c, done_c;
  logic [15:0]  data_c;
  logic [1:0]   k_c;
  logic [1:0]   row_c, col_c;
  logic [287:0] img_c  = {18{16'h3C00}};
  logic [255:0] flt_c  = {{8{16'hBC00}}, {8{16'h3C00}}};

  assign start_a = start && (sel == 0);
  assign start_b = start && (sel == 1);
  assign start_c = start && (sel == 2);

  conv_layer_stream #(.DATA_WIDTH(16), .D(1), .H(4), .W(4), .F(2), .K(1), .S(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .image(img_a), .filters(flt_a),
    .out_valid(vld_a), .out_ready(out_ready), .out_data(data_a), .out_k(k_a),
    .out_row(row_a), .out_col(col_a), .done(done_a));

  conv_layer_stream #(.DATA_WIDTH(16), .D(1), .H(5), .W(5), .F(3), .K(1), .S(2)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .image(img_b), .filters(flt_b),
    .out_valid(vld_b), .out_ready(out_ready), .out_data(data_b), .out_k(k_b),
    .out_row(row_b), .out_col(col_b), .done(done_b));

  conv_layer_stream #(.DATA_WIDTH(16), .D(2), .H(3), .W(3), .F(2), .K(2), .S(1)) dut_c (
    .clk(clk), .reset(reset), .start(start_c), .busy(busy_c), .image(img_c), .filters(flt_c),
    .out_valid(vld_c), .out_ready(out_ready), .out_data(data_c), .out_k(k_c),
    .out_row(row_c), .out_col(col_c), .done(done_c));

  // Observed view of the instance under test.
  logic        o_vld, o_busy, o_done;
  logic [15:0] o_data;
  logic [7:0]  o_k, o_row, o_col;
  always_comb begin
    o_vld = vld_a; o_busy = busy_a; o_done = done_a; o_data = data_a;
    o_k = 8'(k_a); o_row = 8'(row_a); o_col = 8'(col_a);
    if (sel == 1) begin
      o_vld = vld_b; o_busy = busy_b; o_done = done_b; o_data = data_b;
      o_k = 8'(k_b); o_row = 8'(row_b); o_col = 8'(col_b);
    end else if (sel == 2) begin
      o_vld = vld_c; o_busy = busy_c; o_done = done_c; o_data = data_c;
      o_k = 8'(k_c); o_row = 8'(row_c); o_col = 8'(col_c);
    end
  end

  // Expected results of one pass, k outermost, then row, then col.
  task automatic push_pass(input logic [15:0] v0, input logic [15:0] v1, input int nk, input int oh, input int ow);
    exp_t e;
    for (int k = 0; k < nk; k++)
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++) begin
          e.data = (k == 0) ? v0 : v1;
          e.k = 8'(k); e.row = 8'(r); e.col = 8'(c);
          sb.push_back(e);
        end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({vld_a, busy_a, done_a} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got vld/busy/done %b%b%b required 000", vld_a, busy_a, done_a);
    end
    checks++;
    if ({data_a, k_a, row_a, col_a} !== 23'd0) begin
      errors++; $display("FAIL reset_fields: got %h/%0d/%0d/%0d required 0/0/0/0", data_a, k_a, row_a, col_a);
    end
    checks++;
    if ({vld_b, busy_b, vld_c, busy_c} !== 4'b0000) begin
      errors++; $display("FAIL reset_others: got %b%b%b%b required 0000", vld_b, busy_b, vld_c, busy_c);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Config 1, out_ready high: 9 x 4400, first result at t+5, period 5, one done pulse.
  task automatic test_basic;
    int first_n = -1, n_res = 0, n_done = 0, last_hs = -1;
    bit fin = 0;
    exp_t e;
    sel = 0; out_ready = 1'b1; sb.delete();
    push_pass(16'h4400, 16'h4400, 1, 3, 3);
    start = 1'b1;
    for (int n = 1; n <= 200 && !fin; n++) begin
      @(negedge clk); start = 1'b0;
      if (o_vld && first_n < 0) first_n = n;
      if (o_vld && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL basic_extra: got result beyond 9 required none"); end
        else begin
          e = sb.pop_front();
          if ({o_data, o_k, o_row, o_col} !== e) begin
            errors++; $display("FAIL basic_result: got %h k%0d r%0d c%0d required %h k%0d r%0d c%0d",
                               o_data, o_k, o_row, o_col, e.data, e.k, e.row, e.col);
          end
          n_res++;
          if (last_hs >= 0) begin
            checks++;
            if (n - last_hs != 5) begin errors++; $display("FAIL basic_period: got %0d required 5", n - last_hs); end
          end
          last_hs = n;
        end
      end
      if (o_done) begin
        n_done++; fin = 1;
        checks++;
        if (o_busy !== 1'b0 || o_vld !== 1'b0) begin
          errors++; $display("FAIL basic_done_cycle: got busy %b valid %b required 0 0", o_busy, o_vld);
        end
      end
    end
    checks++;
    if (first_n != 5) begin errors++; $display("FAIL basic_latency: got %0d required 5", first_n); end
    checks++;
    if (n_res != 9 || n_done != 1) begin errors++; $display("FAIL basic_count: got %0d results %0d done required 9 1", n_res, n_done); end
    @(negedge clk);
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got done %b busy %b required 0 0", o_done, o_busy); end
  endtask

  // Config 1, first result stalled 5 cycles: fields held, nothing lost.
  task automatic test_stall;
    int first_n = -1, n_res = 0, n_done = 0, stall = 6;
    bit fin = 0;
    exp_t e;
    sel = 0; out_ready = 1'b0; sb.delete();
    push_pass(16'h4400, 16'h4400, 1, 3, 3);
    start = 1'b1;
    for (int n = 1; n <= 300 && !fin; n++) begin
      @(negedge clk); start = 1'b0;
      if (o_vld && first_n < 0) first_n = n;
      if (first_n >= 0 && stall > 0) begin
        checks++;
        if (o_vld !== 1'b1 || {o_data, o_row, o_col} !== {sb[0].data, sb[0].row, sb[0].col}) begin
          errors++; $display("FAIL stall_hold: got v%b %h r%0d c%0d required v1 %h r%0d c%0d",
                             o_vld, o_data, o_row, o_col, sb[0].data, sb[0].row, sb[0].col);
        end
        stall--;
        if (stall == 0) out_ready = 1'b1;
      end
      if (o_vld && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stall_extra: got result beyond 9 required none"); end
        else begin
          e = sb.pop_front();
          if ({o_data, o_k, o_row, o_col} !== e) begin
            errors++; $display("FAIL stall_result: got %h k%0d r%0d c%0d required %h k%0d r%0d c%0d",
                               o_data, o_k, o_row, o_col, e.data, e.k, e.row, e.col);
          end
          n_res++;
        end
      end
      if (o_done) begin n_done++; fin = 1; end
    end
    checks++;
    if (n_res != 9 || n_done != 1) begin errors++; $display("FAIL stall_count: got %0d results %0d done required 9 1", n_res, n_done); end
    out_ready = 1'b1;
    @(negedge clk);
  endtask

  // H=W=5, F=3, S=2: 4 x 4480 at (0,0),(0,1),(1,0),(1,1), first at t+10.
  task automatic test_stride;
    int first_n = -1, n_res = 0, n_done = 0;
    bit fin = 0;
    exp_t e;
    sel = 1; out_ready = 1'b1; sb.delete();
    push_pass(16'h4480, 16'h4480, 1, 2, 2);
    start = 1'b1;
    for (int n = 1; n <= 200 && !fin; n++) begin
      @(negedge clk); start = 1'b0;
      if (o_vld && first_n < 0) first_n = n;
      if (o_vld && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stride_extra: got result beyond 4 required none"); end
        else begin
          e = sb.pop_front();
          if ({o_data, o_k, o_row, o_col} !== e) begin
            errors++; $display("FAIL stride_result: got %h k%0d r%0d c%0d required %h k%0d r%0d c%0d",
                               o_data, o_k, o_row, o_col, e.data, e.k, e.row, e.col);
          end
          n_res++;
        end
      end
      if (o_done) begin n_done++; fin = 1; end
    end
    checks++;
    if (first_n != 10) begin errors++; $display("FAIL stride_latency: got %0d required 10", first_n); end
    checks++;
    if (n_res != 4 || n_done != 1) begin errors++; $display("FAIL stride_count: got %0d results %0d done required 4 1", n_res, n_done); end
    @(negedge clk);
  endtask

  // D=2, K=2: filter 0 gives 4800, filter 1 gives C800 (0000 when clamped).
  task automatic test_multi_filter;
    int n_res = 0, n_done = 0;
    bit fin = 0;
    exp_t e;
    logic [15:0] neg_v;
`ifdef CONV_STREAM_RELU_EN
    neg_v = 16'h0000;
`else
    neg_v = 16'hC800;
`endif
    sel = 2; out_ready = 1'b1; sb.delete();
    push_pass(16'h4800, neg_v, 2, 2, 2);
    start = 1'b1;
    for (int n = 1; n <= 300 && !fin; n++) begin
      @(negedge clk); start = 1'b0;
      if (o_vld && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL multi_extra: got result beyond 8 required none"); end
        else begin
          e = sb.pop_front();
          if ({o_data, o_k, o_row, o_col} !== e) begin
            errors++; $display("FAIL multi_result: got %h k%0d r%0d c%0d required %h k%0d r%0d c%0d",
                               o_data, o_k, o_row, o_col, e.data, e.k, e.row, e.col);
          end
          n_res++;
        end
      end
      if (o_done) begin n_done++; fin = 1; end
    end
    checks++;
    if (n_res != 8 || n_done != 1) begin errors++; $display("FAIL multi_count: got %0d results %0d done required 8 1", n_res, n_done); end
    @(negedge clk);
  endtask

  // Config 1: reset after 3 results, then a fresh pass starts from k=0,row=0,col=0.
  task automatic test_reset_mid;
    int n_res = 0, n_done = 0;
    bit fin = 0;
    exp_t e;
    sel = 0; out_ready = 1'b1; sb.delete();
    push_pass(16'h4400, 16'h4400, 1, 3, 3);
    start = 1'b1;
    for (int n = 1; n <= 100 && n_res < 3; n++) begin
      @(negedge clk); start = 1'b0;
      if (o_vld && out_ready) begin
        e = sb.pop_front(); n_res++;
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (o_vld !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: got valid %b busy %b required 0 0", o_vld, o_busy); end
    sb.delete(); n_res = 0;
    push_pass(16'h4400, 16'h4400, 1, 3, 3);
    start = 1'b1;
    for (int n = 1; n <= 200 && !fin; n++) begin
      @(negedge clk); start = 1'b0;
      if (o_vld && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rstmid_extra: got result beyond 9 required none"); end
        else begin
          e = sb.pop_front();
          if ({o_data, o_k, o_row, o_col} !== e) begin
            errors++; $display("FAIL rstmid_result: got %h k%0d r%0d c%0d required %h k%0d r%0d c%0d",
                               o_data, o_k, o_row, o_col, e.data, e.k, e.row, e.col);
          end
          n_res++;
        end
      end
      if (o_done) begin n_done++; fin = 1; end
    end
    checks++;
    if (n_res != 9 || n_done != 1) begin errors++; $display("FAIL rstmid_count: got %0d results %0d done required 9 1", n_res, n_done); end
    @(negedge clk);
  endtask

  // Config 1: start pulsed mid-pass and in the DONE cycle; both ignored.
  task automatic test_start_ignored;
    int n_res = 0, n_done = 0;
    bit fin = 0;
    exp_t e;
    sel = 0; out_ready = 1'b1; sb.delete();
    push_pass(16'h4400, 16'h4400, 1, 3, 3);
    start = 1'b1;
    for (int n = 1; n <= 200 && !fin; n++) begin
      @(negedge clk); start = (n == 12);
      if (o_vld && out_ready) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL restart_extra: got result beyond 9 required none"); end
        else begin
          e = sb.pop_front();
          if ({o_data, o_k, o_row, o_col} !== e) begin
            errors++; $display("FAIL restart_result: got %h k%0d r%0d c%0d required %h k%0d r%0d c%0d",
                               o_data, o_k, o_row, o_col, e.data, e.k, e.row, e.col);
          end
          n_res++;
        end
      end
      if (o_done) begin n_done++; fin = 1; start = 1'b1; end
    end
    checks++;
    if (n_res != 9 || n_done != 1) begin errors++; $display("FAIL restart_count: got %0d results %0d done required 9 1", n_res, n_done); end
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (o_busy !== 1'b0 || o_vld !== 1'b0) begin errors++; $display("FAIL restart_done_start: got busy %b valid %b required 0 0", o_busy, o_vld); end
    repeat (3) @(negedge clk);
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin errors++; $display("FAIL restart_idle: got busy %b done %b required 0 0", o_busy, o_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_stride();
    test_multi_filter();
    test_reset_mid();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
